// File: rtl/conv_window_feeder_if.sv
// Stream/kernel/MAC-lane bundle for conv_window_feeder.
// master = pixel/kernel source and MAC consumer, slave = the feeder.
interface conv_window_feeder_if;
    logic        in_valid;
    logic [7:0]  in_pixel;
    logic        in_ready;
    logic        k_we;
    logic [3:0]  k_addr;
    logic [7:0]  k_data;
    logic [23:0] data_out;
    logic [23:0] weight_out;
    logic        win_valid;
    logic        res_valid;
    logic        res_last;

    modport master (
        output in_valid, in_pixel, k_we, k_addr, k_data,
        input  in_ready, data_out, weight_out, win_valid, res_valid, res_last
    );

    modport slave (
        input  in_valid, in_pixel, k_we, k_addr, k_data,
        output in_ready, data_out, weight_out, win_valid, res_valid, res_last
    );
endinterface

// File: rtl/conv_window_feeder.sv
// 3x3 window former feeding a 3-cycle-per-row MAC in 4-cycle slots.
// Optional KERNEL_LOCK_EN: kernel writes only at (0,0) in phase 0 (between images).
module conv_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input logic                  clk,
    input logic                  rst,
    conv_window_feeder_if.slave  bus
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [1:0]    phase_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    lb0_q [IMG_W];
    logic [7:0]    lb1_q [IMG_W];
    logic [7:0]    win_q [3][3];
    logic [7:0]    kern_q [9];
    logic          slot_valid_q;
    logic          slot_last_q;

    logic          accept_s;
    logic          kwr_s;
    logic          slot_ok_s;
    logic          at_last_s;
    logic [23:0]   data_s;
    logic [23:0]   weight_s;
    logic          win_valid_s;

    assign accept_s  = bus.in_valid & (phase_q == 2'd0);
    assign slot_ok_s = (row_q >= ROW_TWO) & (col_q >= COL_TWO);
    assign at_last_s = (row_q == ROW_LAST) & (col_q == COL_LAST);

`ifdef KERNEL_LOCK_EN
    logic lock_ok_s;
    assign lock_ok_s = (row_q == {RW{1'b0}}) & (col_q == {CW{1'b0}}) & (phase_q == 2'd0);
    assign kwr_s     = bus.k_we & (bus.k_addr <= 4'd8) & lock_ok_s;
`else
    assign kwr_s     = bus.k_we & (bus.k_addr <= 4'd8);
`endif

    // Raster position advance on each accepted pixel, wrapping at image end.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept_s) begin
            if (col_q == COL_LAST) begin
                col_d = {CW{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Line buffers: no reset, stale data is masked by the row>=2 gating.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= bus.in_pixel;
        end
    end

    // Phase counter, position, window, kernel and slot status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q      <= 2'd0;
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            slot_valid_q <= 1'b0;
            slot_last_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= 8'd0;
                end
            end
            for (int k = 0; k < 9; k++) begin
                kern_q[k] <= 8'd0;
            end
        end else begin
            phase_q <= phase_q + 2'd1;
            col_q   <= col_d;
            row_q   <= row_d;
            if (phase_q == 2'd0) begin
                slot_valid_q <= accept_s & slot_ok_s;
                slot_last_q  <= accept_s & at_last_s;
            end
            if (accept_s) begin
                // Row 0 is the oldest line (r-2), column 2 the newest pixel.
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb1_q[col_q];
                win_q[1][2] <= lb0_q[col_q];
                win_q[2][2] <= bus.in_pixel;
            end
            if (kwr_s) begin
                kern_q[bus.k_addr] <= bus.k_data;
            end
        end
    end

    // Phase 1..3 of a valid slot present window/kernel row (phase-1).
    always_comb begin
        data_s      = 24'd0;
        weight_s    = 24'd0;
        win_valid_s = 1'b0;
        if (slot_valid_q) begin
            case (phase_q)
                2'd1: begin
                    data_s      = {win_q[0][2], win_q[0][1], win_q[0][0]};
                    weight_s    = {kern_q[2], kern_q[1], kern_q[0]};
                    win_valid_s = 1'b1;
                end
                2'd2: begin
                    data_s      = {win_q[1][2], win_q[1][1], win_q[1][0]};
                    weight_s    = {kern_q[5], kern_q[4], kern_q[3]};
                    win_valid_s = 1'b1;
                end
                2'd3: begin
                    data_s      = {win_q[2][2], win_q[2][1], win_q[2][0]};
                    weight_s    = {kern_q[8], kern_q[7], kern_q[6]};
                    win_valid_s = 1'b1;
                end
                default: begin
                    data_s      = 24'd0;
                    weight_s    = 24'd0;
                    win_valid_s = 1'b0;
                end
            endcase
        end else begin
            data_s      = 24'd0;
            weight_s    = 24'd0;
            win_valid_s = 1'b0;
        end
    end

    assign bus.in_ready   = (phase_q == 2'd0);
    assign bus.data_out   = data_s;
    assign bus.weight_out = weight_s;
    assign bus.win_valid  = win_valid_s;
    assign bus.res_valid  = (phase_q == 2'd0) & slot_valid_q;
    assign bus.res_last   = (phase_q == 2'd0) & slot_valid_q & slot_last_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed + randomized bench for conv_window_feeder on a 4x4 image,
// with a MAC accumulator and an image/kernel reference model.
module tb_conv_window_feeder;
    localparam int W = 4;
    localparam int H = 4;
`ifdef KERNEL_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_window_feeder_if bus ();
    conv_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int ph, mr, mc, sr, sc;
    int img [H][W];
    int kmod [9];
    int kset [9];
    bit sv_m, sl_m;
    int exp_q [$];
    bit exp_last_q [$];
    int res_log [$];
    int acc;
    logic [23:0] first_d, w_ph2;
    bit got_first;

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        ph = 0; mr = 0; mc = 0; sv_m = 1'b0; sl_m = 1'b0; acc = 0;
        for (int i = 0; i < 9; i++) kmod[i] = 0;
        exp_q.delete();
        exp_last_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_pixel = 8'd0;
        bus.k_we = 1'b0; bus.k_addr = 4'd0; bus.k_data = 8'd0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_last", bus.res_last, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_weight", bus.weight_out, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One clock: drive at negedge, check, then advance the reference model.
    task automatic do_cycle(input bit v, input logic [7:0] p, input bit kwe,
                            input logic [3:0] ka, input logic [7:0] kd);
        logic [23:0] ed, ew;
        bit ewv;
        int s;
        bus.in_valid = v; bus.in_pixel = p;
        bus.k_we = kwe; bus.k_addr = ka; bus.k_data = kd;
        #1;
        chk("in_ready", bus.in_ready, (ph == 0));
        ewv = sv_m && (ph != 0);
        ed = 24'd0; ew = 24'd0;
        if (ewv) begin
            for (int j = 0; j < 3; j++) begin
                ed[8*j +: 8] = 8'(img[sr-2+ph-1][sc-2+j]);
                ew[8*j +: 8] = 8'(kmod[(ph-1)*3+j]);
            end
        end
        chk("win_valid", bus.win_valid, ewv);
        chk("data_out", bus.data_out, ed);
        chk("weight_out", bus.weight_out, ew);
        if (ph == 0) begin
            chk("res_valid", bus.res_valid, sv_m);
            if (sv_m) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    chk("mac_result", acc, exp_q.pop_front());
                    chk("res_last", bus.res_last, exp_last_q.pop_front());
                end
                res_log.push_back(acc);
            end else begin
                chk("res_last_idle", bus.res_last, 0);
            end
            acc = 0;
        end
        for (int j = 0; j < 3; j++)
            acc += sx(bus.data_out[8*j +: 8]) * sx(bus.weight_out[8*j +: 8]);
        if (ewv && ph == 1 && !got_first) begin
            first_d = bus.data_out;
            got_first = 1'b1;
        end
        if (ewv && ph == 2) w_ph2 = bus.weight_out;
        @(posedge clk);
        if (kwe && ka <= 4'd8 && (!LOCK || (ph == 0 && mr == 0 && mc == 0)))
            kmod[ka] = sx(kd);
        if (ph == 0) begin
            sv_m = v && mr >= 2 && mc >= 2;
            sl_m = v && mr == H-1 && mc == W-1;
            if (v) begin
                img[mr][mc] = sx(p);
                if (sv_m) begin
                    sr = mr; sc = mc;
                    s = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            s += img[mr-2+i][mc-2+j] * kmod[i*3+j];
                    exp_q.push_back(s);
                    exp_last_q.push_back(sl_m);
                end
                mc++;
                if (mc == W) begin
                    mc = 0; mr++;
                    if (mr == H) mr = 0;
                end
            end
        end
        ph = (ph + 1) % 4;
        @(negedge clk);
    endtask

    task automatic load_kernel();
        for (int i = 0; i < 9; i++) begin
            do_cycle(1'b0, 8'd0, 1'b1, 4'(i), 8'(kset[i]));
            repeat (3) do_cycle(1'b0, 8'd0, 1'b0, 4'd0, 8'd0);
        end
        do_cycle(1'b0, 8'd0, 1'b1, 4'd12, 8'h55);
        repeat (3) do_cycle(1'b0, 8'd0, 1'b0, 4'd0, 8'd0);
    endtask

    // mode: 0=1..16, 1=127, 2=random; skip: 0 none, 1 every 2nd slot, 2 random.
    task automatic run_image(input int mode, input int skip, input int kw_at, input int n_max);
        int n, s;
        bit v;
        logic [7:0] p;
        n = 0; s = 0;
        while (n < n_max) begin
            v = (skip == 0) ? 1'b1 : (skip == 1) ? (s % 2 == 0) : ($urandom_range(0, 3) != 0);
            p = (mode == 0) ? 8'(n + 1) : (mode == 1) ? 8'd127 : 8'($urandom);
            do_cycle(v, p, (kw_at == n) && v, 4'd0, 8'd5);
            repeat (3) do_cycle(v, p, 1'b0, 4'd0, 8'd0);
            if (v) n++;
            s++;
        end
        if (n_max == W*H) begin
            repeat (4) do_cycle(1'b0, 8'd0, 1'b0, 4'd0, 8'd0);
            chk("pending_results", exp_q.size(), 0);
        end
    endtask

    task automatic check_ramp(input string tag);
        chk({tag, "_count"}, res_log.size(), 4);
        if (res_log.size() == 4) begin
            chk({tag, "_r0"}, res_log[0], 54);
            chk({tag, "_r1"}, res_log[1], 63);
            chk({tag, "_r2"}, res_log[2], 90);
            chk({tag, "_r3"}, res_log[3], 99);
        end
    endtask

    initial begin
        do_reset();

        // Scenario 1: all-ones kernel, ramp image, continuous input.
        for (int i = 0; i < 9; i++) kset[i] = 1;
        load_kernel();
        res_log.delete(); got_first = 1'b0;
        run_image(0, 0, -1, W*H);
        check_ramp("ramp");
        chk("first_row_data", first_d, 24'h030201);

        // Scenario 2: every second slot empty.
        res_log.delete();
        run_image(0, 1, -1, W*H);
        check_ramp("skip");

        // Scenario 3: centre tap -1 on a flat 127 image.
        for (int i = 0; i < 9; i++) kset[i] = 0;
        kset[4] = -1;
        load_kernel();
        res_log.delete(); w_ph2 = 24'd0;
        run_image(1, 0, -1, W*H);
        chk("neg_count", res_log.size(), 4);
        foreach (res_log[i]) chk("neg_result", res_log[i], -127);
        chk("neg_weight_ph2", w_ph2, 24'h00FF00);

        // Scenario 4: reset after 7 pixels, then a clean image.
        run_image(0, 0, -1, 7);
        do_reset();
        for (int i = 0; i < 9; i++) kset[i] = 1;
        load_kernel();
        res_log.delete();
        run_image(0, 0, -1, W*H);
        check_ramp("after_rst");

        // Scenario 5: k[0]=5 at (1,2) mid-image, then again between images.
        res_log.delete();
        run_image(0, 0, 6, W*H);
        chk("lock_mid_first", res_log.size() > 0 ? res_log[0] : -1, LOCK ? 54 : 58);
        do_cycle(1'b0, 8'd0, 1'b1, 4'd0, 8'd5);
        repeat (3) do_cycle(1'b0, 8'd0, 1'b0, 4'd0, 8'd0);
        res_log.delete();
        run_image(0, 0, -1, W*H);
        chk("lock_idle_first", res_log.size() > 0 ? res_log[0] : -1, 58);

        // Scenario 6: random kernels, pixels and input gaps.
        for (int img_i = 0; img_i < 3; img_i++) begin
            for (int i = 0; i < 9; i++) kset[i] = int'($signed(8'($urandom)));
            load_kernel();
            res_log.delete();
            run_image(2, 2, -1, W*H);
            chk("rand_count", res_log.size(), 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
